// File: rtl/key_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : key_event_arbiter
// Purpose  : Four debounced pushbuttons, each turned into a press-and-release
//            event, queued as pending flags and offered round-robin on a
//            valid/ready handshake. Optional macro: KEY_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_arbiter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       event_ready,
    output logic       event_valid,
    output logic [1:0] event_id,
    output logic [3:0] pending,
    output logic       overrun
);

    localparam int c_NUM_KEYS = 4;

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_RELEASED = 2'd2
    } key_state_e;

    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] filt;
    logic [3:0] rel;

    logic [3:0] pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic       event_valid_q, event_valid_d;
    logic [1:0] event_id_q, event_id_d;
    logic [1:0] last_grant_q, last_grant_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar i = 0; i < c_NUM_KEYS; i++) begin : g_key
`ifdef KEY_DEBOUNCE_EN
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             filt_q, filt_d;

        if (DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_range_check
            $error("DEBOUNCE_CYCLES does not fit in CNT_W bits");
        end

        // Counter runs only while the synchronized level disagrees with the
        // accepted level; any agreement restarts the stability window.
        always_comb begin
            cnt_d  = '0;
            filt_d = filt_q;
            if (sync2_q[i] != filt_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d = sync2_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q  <= '0;
                filt_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_d;
                filt_q <= filt_d;
            end
        end

        assign filt[i] = filt_q;
`else
        assign filt[i] = sync2_q[i];
`endif

        key_state_e state_q, state_d;

        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_FREE:     if (!filt[i]) state_d = ST_PRESSED;
                ST_PRESSED:  if (filt[i])  state_d = ST_RELEASED;
                ST_RELEASED: state_d = ST_FREE;
                default:     state_d = ST_FREE;
            endcase
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= ST_FREE;
            end else begin
                state_q <= state_d;
            end
        end

        assign rel[i] = (state_q == ST_RELEASED);
    end

    logic       accept;
    logic [3:0] acc_vec;
    logic [3:0] eligible;
    logic [1:0] rr_base;
    logic [1:0] rr_idx;
    logic [1:0] rr_sel;
    logic       rr_found;

    always_comb begin
        accept   = event_valid_q & event_ready;
        acc_vec  = accept ? (4'b0001 << event_id_q) : 4'b0000;
        eligible = pending_q & ~acc_vec;
        // On an acceptance the grant being retired becomes the new last_grant,
        // so the search starts just past it in the same cycle.
        rr_base  = accept ? event_id_q : last_grant_q;
        rr_idx   = rr_base;
        rr_sel   = rr_base;
        rr_found = 1'b0;
        for (int k = 1; k <= c_NUM_KEYS; k++) begin
            rr_idx = rr_base + 2'(k);
            if (!rr_found && eligible[rr_idx]) begin
                rr_found = 1'b1;
                rr_sel   = rr_idx;
            end
        end

        pending_d     = (pending_q & ~acc_vec) | rel;
        overrun_d     = overrun_q | (|(rel & pending_q & ~acc_vec));
        last_grant_d  = accept ? event_id_q : last_grant_q;
        event_valid_d = event_valid_q;
        event_id_d    = event_id_q;
        if (!event_valid_q || accept) begin
            event_valid_d = rr_found;
            if (rr_found) begin
                event_id_d = rr_sel;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q     <= 4'b0000;
            overrun_q     <= 1'b0;
            event_valid_q <= 1'b0;
            event_id_q    <= 2'd0;
            last_grant_q  <= 2'd3;
        end else begin
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            event_valid_q <= event_valid_d;
            event_id_q    <= event_id_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign event_valid = event_valid_q;
    assign event_id    = event_id_q;
    assign pending     = pending_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_event_arbiter
// Purpose  : Directed, table-driven self-checking bench for key_event_arbiter
//            (DEBOUNCE_CYCLES=4; timing expectations follow KEY_DEBOUNCE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_arbiter;

`ifdef KEY_DEBOUNCE_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic       event_ready;
    logic       event_valid;
    logic [1:0] event_id;
    logic [3:0] pending;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_id[$];
    int acc_cyc[$];

    typedef struct {
        logic [3:0] key_n;
        int         hold;
        int         exp_id;
        int         exp_lat;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t vecs[4];

    key_event_arbiter #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_n      (key_n),
        .event_ready(event_ready),
        .event_valid(event_valid),
        .event_id   (event_id),
        .pending    (pending),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset && event_valid && event_ready) begin
            acc_id.push_back(int'(event_id));
            acc_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qget(input int idx);
        if (idx < acc_id.size()) return acc_id[idx];
        return -1;
    endfunction

    function automatic int cget(input int idx);
        if (idx < acc_cyc.size()) return acc_cyc[idx];
        return -1000;
    endfunction

    task automatic clear_acc();
        acc_id.delete();
        acc_cyc.delete();
    endtask

    int seen;
    int bad;

    task automatic step_bp(input int n);
        repeat (n) begin
            tick(1);
            if (event_valid) seen = 1;
            if (seen != 0 && (!event_valid || event_id != 2'd1)) bad++;
        end
    endtask

    initial begin
        int rel_cyc;
        int first;
        int pend_seen;
        int nonzero;

        vecs[0] = '{4'b1011, 10, 2, 5 + FL, 4'b0100};
        vecs[1] = '{4'b1110,  8, 0, 5 + FL, 4'b0001};
        vecs[2] = '{4'b0111, 10, 3, 5 + FL, 4'b1000};
        vecs[3] = '{4'b1101,  6, 1, 5 + FL, 4'b0010};

        reset       = 1'b1;
        key_n       = 4'hF;
        event_ready = 1'b1;
        tick(3);
        chk("reset_valid",   int'(event_valid), 0);
        chk("reset_id",      int'(event_id),    0);
        chk("reset_pending", int'(pending),     0);
        chk("reset_overrun", int'(overrun),     0);
        reset = 1'b0;
        tick(2);

        // Single-key press/release vectors
        for (int i = 0; i < 4; i++) begin
            clear_acc();
            key_n = vecs[i].key_n;
            tick(vecs[i].hold);
            key_n     = 4'hF;
            rel_cyc   = cyc;
            first     = -1;
            pend_seen = 0;
            for (int c = 0; c < 20; c++) begin
                tick(1);
                if (event_valid && first < 0) first = cyc - rel_cyc;
                if (pending == vecs[i].exp_pend) pend_seen = 1;
            end
            chk($sformatf("vec%0d_events", i),  acc_id.size(), 1);
            chk($sformatf("vec%0d_id", i),      qget(0), vecs[i].exp_id);
            chk($sformatf("vec%0d_latency", i), first, vecs[i].exp_lat);
            chk($sformatf("vec%0d_pend_set", i), pend_seen, 1);
            chk($sformatf("vec%0d_pend_clr", i), int'(pending), 0);
            chk($sformatf("vec%0d_overrun", i), int'(overrun), 0);
        end

        // Bounce on key 0
        clear_acc();
        for (int c = 0; c < 12; c++) begin
            key_n = (((c / 2) % 2) == 0) ? 4'hE : 4'hF;
            tick(1);
        end
        key_n = 4'hE;
        tick(10);
        key_n = 4'hF;
        tick(20);
        nonzero = 0;
        foreach (acc_id[j]) if (acc_id[j] != 0) nonzero++;
`ifdef KEY_DEBOUNCE_EN
        chk("bounce_events", acc_id.size(), 1);
`else
        chk("bounce_events", acc_id.size(), 4);
`endif
        chk("bounce_ids", nonzero, 0);

        // Single-cycle pulse on key 3
        clear_acc();
        key_n = 4'h7;
        tick(1);
        key_n   = 4'hF;
        rel_cyc = cyc;
        first   = -1;
        for (int c = 0; c < 15; c++) begin
            tick(1);
            if (event_valid && first < 0) first = cyc - rel_cyc;
        end
`ifdef KEY_DEBOUNCE_EN
        chk("pulse_events", acc_id.size(), 0);
`else
        chk("pulse_events",  acc_id.size(), 1);
        chk("pulse_id",      qget(0), 3);
        chk("pulse_latency", first, 5);
`endif

        // Round-robin: keys 0, 1, 3 together, then 0, 1
        clear_acc();
        key_n = 4'b0100;
        tick(8);
        key_n = 4'hF;
        tick(20);
        chk("rr1_events", acc_id.size(), 3);
        chk("rr1_id0", qget(0), 0);
        chk("rr1_id1", qget(1), 1);
        chk("rr1_id2", qget(2), 3);
        chk("rr1_gap1", cget(1) - cget(0), 1);
        chk("rr1_gap2", cget(2) - cget(1), 1);
        clear_acc();
        key_n = 4'b1100;
        tick(8);
        key_n = 4'hF;
        tick(20);
        chk("rr2_events", acc_id.size(), 2);
        chk("rr2_id0", qget(0), 0);
        chk("rr2_id1", qget(1), 1);

        // Backpressure with a coalesced second event on key 1
        clear_acc();
        event_ready = 1'b0;
        seen = 0;
        bad  = 0;
        key_n = 4'b1101;
        step_bp(8);
        key_n = 4'hF;
        step_bp(12);
        key_n = 4'b1101;
        step_bp(8);
        key_n = 4'hF;
        step_bp(14);
        chk("bp_seen",    seen, 1);
        chk("bp_stable",  bad, 0);
        chk("bp_overrun", int'(overrun), 1);
        chk("bp_pending", int'(pending), 2);
        chk("bp_valid",   int'(event_valid), 1);
        chk("bp_id",      int'(event_id), 1);
        chk("bp_no_acc",  acc_id.size(), 0);
        event_ready = 1'b1;
        tick(4);
        chk("bp_acc_count",   acc_id.size(), 1);
        chk("bp_pending_clr", int'(pending), 0);
        chk("bp_valid_clr",   int'(event_valid), 0);
        chk("bp_overrun_sticky", int'(overrun), 1);

        // Reset while an event is offered and another is pending
        clear_acc();
        event_ready = 1'b0;
        key_n = 4'b1010;
        tick(8);
        key_n = 4'hF;
        first = 0;
        for (int c = 0; c < 20 && !event_valid; c++) tick(1);
        chk("rst_mid_valid_before", int'(event_valid), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rst_mid_valid",   int'(event_valid), 0);
        chk("rst_mid_pending", int'(pending), 0);
        chk("rst_mid_overrun", int'(overrun), 0);
        event_ready = 1'b1;
        tick(15);
        chk("rst_mid_no_acc",  acc_id.size(), 0);
        chk("rst_mid_pending_after", int'(pending), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
